// File: rtl/instr_assembler.sv
`default_nettype none
// ============================================================================
// Module      : instr_assembler
// Description : Packs MIPS R/I/J field tuples into 32-bit instruction words
//               and writes them to consecutive instruction-memory byte
//               addresses. Acts as the program loader that fills instruction
//               memory before the CPU is released from reset.
// Ports       : clk, rst             - clock, synchronous active-high reset
//               start, base_addr,
//               word_count           - load command (sampled in IDLE only)
//               in_valid / in_ready  - field-tuple handshake
//               fmt, opcode, rs, rt,
//               rd, shamt, func,
//               imme16, imme26       - instruction fields (fmt 0=R 1=I 2=J)
//               mem_we / mem_ready   - write handshake, held until accepted
//               mem_addr, mem_wdata  - write byte address and packed word
//               busy, done, err      - status (done is a 1-cycle pulse,
//                                      err is sticky for an illegal fmt)
// Revision    : 1.0 - initial release
// ============================================================================
module instr_assembler #(
    parameter int ADDR_W  = 32,
    parameter int COUNT_W = 10
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [ADDR_W-1:0]  base_addr,
    input  logic [COUNT_W-1:0] word_count,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [1:0]         fmt,
    input  logic [5:0]         opcode,
    input  logic [4:0]         rs,
    input  logic [4:0]         rt,
    input  logic [4:0]         rd,
    input  logic [4:0]         shamt,
    input  logic [5:0]         func,
    input  logic [15:0]        imme16,
    input  logic [25:0]        imme26,
    output logic               mem_we,
    input  logic               mem_ready,
    output logic [ADDR_W-1:0]  mem_addr,
    output logic [31:0]        mem_wdata,
    output logic               busy,
    output logic               done,
    output logic               err
);

    localparam logic [1:0] c_idle = 2'd0;
    localparam logic [1:0] c_run  = 2'd1;
    localparam logic [1:0] c_done = 2'd2;

    localparam logic [1:0] c_fmt_r = 2'd0;
    localparam logic [1:0] c_fmt_i = 2'd1;
    localparam logic [1:0] c_fmt_j = 2'd2;

    localparam logic [ADDR_W-1:0]  c_addr_step = ADDR_W'(4);
    localparam logic [COUNT_W-1:0] c_cnt_one   = COUNT_W'(1);

    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;
    logic [COUNT_W-1:0] r_remaining;
    logic               r_mem_we;
    logic [ADDR_W-1:0]  r_mem_addr;
    logic [31:0]        r_mem_wdata;
    logic               r_err;

    logic               w_write_done;
    logic               w_slot_free;
    logic               w_in_ready;
    logic               w_accept;
    logic               w_legal;
    logic [31:0]        w_packed;

    // The output register can take a new word when it is empty or when the
    // word it holds is being written this cycle.
    assign w_write_done = r_mem_we & mem_ready;
    assign w_slot_free  = ~r_mem_we | mem_ready;
    assign w_in_ready   = (r_state == c_run) && (r_remaining != '0) && w_slot_free;
    assign w_accept     = in_valid & w_in_ready;
    assign w_legal      = (fmt != 2'd3);

    always_comb begin
        w_packed = 32'd0;
        case (fmt)
            c_fmt_r: w_packed = {opcode, rs, rt, rd, shamt, func};
            c_fmt_i: w_packed = {opcode, rs, rt, imme16};
            c_fmt_j: w_packed = {opcode, imme26};
            default: w_packed = 32'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // RUN finishes only once the final word has left the output register.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_idle: begin
                if (start) begin
                    w_state_nxt = (word_count == '0) ? c_done : c_run;
                end
            end
            c_run: begin
                if ((r_remaining == '0) && !r_mem_we) begin
                    w_state_nxt = c_done;
                end
            end
            c_done:  w_state_nxt = c_idle;
            default: w_state_nxt = c_idle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_remaining <= '0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= 32'd0;
            r_err       <= 1'b0;
        end else if ((r_state == c_idle) && start) begin
            r_remaining <= word_count;
            r_mem_addr  <= base_addr;
            r_err       <= 1'b0;
        end else begin
            if (w_accept && !w_legal) begin
                r_err <= 1'b1;
            end
            if (w_accept && w_legal) begin
                r_mem_we    <= 1'b1;
                r_mem_wdata <= w_packed;
                r_remaining <= r_remaining - c_cnt_one;
            end else if (w_write_done) begin
                r_mem_we <= 1'b0;
            end
            // The address register always points at the word being (or next
            // to be) written, so it advances only when a write completes.
            if (w_write_done) begin
                r_mem_addr <= r_mem_addr + c_addr_step;
            end
        end
    end

    assign in_ready  = w_in_ready;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign busy      = (r_state != c_idle);
    assign done      = (r_state == c_done);
    assign err       = r_err;

endmodule
`default_nettype wire
